// File: rtl/logicnet_input_quantizer.sv
// Streaming 2-bit feature quantizer that packs N_FEAT codes into one vector for layer0.
// Define QUANT_STATS_EN to add vec_count/err_count statistics outputs.
module logicnet_input_quantizer #(
  parameter int unsigned N_FEAT = 16,
  parameter int unsigned IN_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [IN_W-1:0]             s_data,
  input  logic                        s_last,
  input  logic                        cfg_we,
  input  logic [$clog2(N_FEAT)-1:0]   cfg_feat,
  input  logic [1:0]                  cfg_sel,
  input  logic [IN_W-1:0]             cfg_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [2*N_FEAT-1:0]         m_data,
  output logic                        err_len
`ifdef QUANT_STATS_EN
  ,
  output logic [15:0]                 vec_count,
  output logic [15:0]                 err_count
`endif
);

  localparam int unsigned OUT_W = 2 * N_FEAT;
  localparam int unsigned IDX_W = $clog2(N_FEAT);
  localparam logic [IN_W-1:0] T0_RST = {2'b11, (IN_W-2)'(0)};
  localparam logic [IN_W-1:0] T1_RST = '0;
  localparam logic [IN_W-1:0] T2_RST = {2'b01, (IN_W-2)'(0)};

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [OUT_W-1:0]     stage_q, stage_d;
  logic [OUT_W-1:0]     m_data_q, m_data_d;
  logic                 s_ready_q, s_ready_d;
  logic                 m_valid_q, m_valid_d;
  logic                 err_len_q, err_len_d;

  logic signed [IN_W-1:0] t0_q [N_FEAT];
  logic signed [IN_W-1:0] t1_q [N_FEAT];
  logic signed [IN_W-1:0] t2_q [N_FEAT];

  logic signed [IN_W-1:0] x_c;
  logic                   ge0_c, ge1_c, ge2_c;
  logic [1:0]             code_c;
  logic                   idx_last_c;
  logic                   cfg_ok_c;

  // Code is the number of thresholds passed; thresholds need not be ordered.
  assign x_c        = $signed(s_data);
  assign ge0_c      = x_c >= t0_q[idx_q];
  assign ge1_c      = x_c >= t1_q[idx_q];
  assign ge2_c      = x_c >= t2_q[idx_q];
  assign code_c     = 2'(ge0_c) + 2'(ge1_c) + 2'(ge2_c);
  assign idx_last_c = (idx_q == IDX_W'(N_FEAT - 1));
  assign cfg_ok_c   = cfg_we && (32'(cfg_feat) < N_FEAT);

  // Threshold table; a same-cycle write is seen only by later beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FEAT; i++) begin
        t0_q[i] <= T0_RST;
        t1_q[i] <= T1_RST;
        t2_q[i] <= T2_RST;
      end
    end else if (cfg_ok_c) begin
      case (cfg_sel)
        2'd0:    t0_q[cfg_feat] <= cfg_data;
        2'd1:    t1_q[cfg_feat] <= cfg_data;
        2'd2:    t2_q[cfg_feat] <= cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      stage_q   <= '0;
      m_data_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      m_data_q  <= m_data_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_len_q <= err_len_d;
    end
  end

  // Staging is cleared on completion so a short vector leaves zeros in unused slices.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    m_data_d  = m_data_q;
    err_len_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (s_valid && s_ready_q) begin
          stage_d[{idx_q, 1'b0} +: 2] = code_c;
          if (s_last || idx_last_c) begin
            m_data_d  = stage_d;
            stage_d   = '0;
            idx_d     = '0;
            state_d   = HOLD;
            err_len_d = (s_last != idx_last_c);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (m_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    s_ready_d = (state_d == COLLECT);
    m_valid_d = (state_d == HOLD);
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err_len = err_len_q;

`ifdef QUANT_STATS_EN
  logic [15:0] vec_count_q, err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count_q <= '0;
      err_count_q <= '0;
    end else begin
      if (m_valid_q && m_ready) vec_count_q <= vec_count_q + 16'd1;
      if (err_len_q)            err_count_q <= err_count_q + 16'd1;
    end
  end

  assign vec_count = vec_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Directed bench for logicnet_input_quantizer: vector table plus handshake/reset/config sequences.
module tb_logicnet_input_quantizer;

  localparam int unsigned N_FEAT = 16;
  localparam int unsigned IN_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, s_last;
  logic [IN_W-1:0]   s_data;
  logic              cfg_we;
  logic [3:0]        cfg_feat;
  logic [1:0]        cfg_sel;
  logic [IN_W-1:0]   cfg_data;
  logic              m_valid, m_ready;
  logic [31:0]       m_data;
  logic              err_len;
`ifdef QUANT_STATS_EN
  logic [15:0]       vec_count, err_count;
`endif

  int checks = 0;
  int errors = 0;

  logicnet_input_quantizer #(.N_FEAT(N_FEAT), .IN_W(IN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .cfg_we   (cfg_we),
    .cfg_feat (cfg_feat),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .err_len  (err_len)
`ifdef QUANT_STATS_EN
    ,
    .vec_count(vec_count),
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    int           len;
    bit           use_last;
    logic [31:0]  exp_data;
    bit           exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: s_ready stuck at %b expected 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_vec(input logic [255:0] d, input int len, input bit use_last,
                         input logic [31:0] exp_d, input bit exp_e, input string tag);
    for (int b = 0; b < len; b++) send_beat(d[16*b +: 16], use_last && (b == len - 1));
    chk({tag, "_mvalid_rise"}, 32'(m_valid), 32'd1);
    chk({tag, "_mdata"}, m_data, exp_d);
    chk({tag, "_err"}, 32'(err_len), 32'(exp_e));
    @(negedge clk);
    chk({tag, "_err_fall"}, 32'(err_len), 32'd0);
    chk({tag, "_mvalid_fall"}, 32'(m_valid), 32'd0);
  endtask

  task automatic cfg_write(input logic [3:0] f, input logic [1:0] sel, input logic [IN_W-1:0] v);
    cfg_we = 1'b1; cfg_feat = f; cfg_sel = sel; cfg_data = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [255:0] alt;
    logic [31:0]  held;
    alt = {4{16'sd20000, 16'sd0, -16'sd1, -16'sd20000}};
    tbl[0] = '{alt,               16, 1'b1, 32'hE4E4E4E4, 1'b0};
    tbl[1] = '{{16{16'sd30000}},   5, 1'b1, 32'h000003FF, 1'b1};
    tbl[2] = '{{16{16'sd16384}},  16, 1'b0, 32'hFFFFFFFF, 1'b1};
    tbl[3] = '{{16{-16'sd16385}}, 16, 1'b1, 32'h00000000, 1'b0};
    tbl[4] = '{{16{-16'sd16384}}, 16, 1'b1, 32'h55555555, 1'b0};
    tbl[5] = '{{16{16'sd0}},       2, 1'b1, 32'h0000000A, 1'b1};
    tbl[6] = '{{16{-16'sd1}},      1, 1'b1, 32'h00000001, 1'b1};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_feat = '0; cfg_sel = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 7; i++)
      run_vec(tbl[i].data, tbl[i].len, tbl[i].use_last, tbl[i].exp_data, tbl[i].exp_err,
              $sformatf("tbl%0d", i));

    // Per-feature thresholds; the sel==3 write must be ignored.
    cfg_write(4'd2, 2'd0, 16'sd100);
    cfg_write(4'd2, 2'd1, 16'sd100);
    cfg_write(4'd2, 2'd2, 16'sd100);
    cfg_write(4'd0, 2'd3, 16'sd32767);
    run_vec({16{16'sd100}}, 16, 1'b1, 32'hAAAAAABA, 1'b0, "feat2_cfg");

    // Backpressure: vector held, pending beat must wait for the handshake.
    m_ready = 1'b0;
    for (int b = 0; b < 16; b++) send_beat(16'sd30000, b == 15);
    chk("hold_mvalid", 32'(m_valid), 32'd1);
    held = m_data;
    chk("hold_mdata", held, 32'hFFFFFFFF);
    s_valid = 1'b1; s_data = -16'sd20000; s_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_s_ready", 32'(s_ready), 32'd0);
      chk("hold_m_valid", 32'(m_valid), 32'd1);
      chk("hold_stable", m_data, 32'hFFFFFFFF);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("hs_mvalid_drop", 32'(m_valid), 32'd0);
    chk("hs_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    for (int b = 0; b < 15; b++) send_beat(16'sd30000, b == 14);
    chk("after_hold_mdata", m_data, 32'hFFFFFFFC);
    chk("after_hold_err", 32'(err_len), 32'd0);
    @(negedge clk);

    // Threshold write to the feature being quantized in the same cycle.
    cfg_we = 1'b1; cfg_feat = 4'd0; cfg_sel = 2'd1; cfg_data = 16'sd1000;
    send_beat(16'sd50, 1'b0);
    cfg_we = 1'b0;
    send_beat(16'sd50, 1'b1);
    chk("samecyc_old_thr", m_data, 32'h0000000A);
    chk("samecyc_err", 32'(err_len), 32'd1);
    @(negedge clk);
    run_vec({16{16'sd50}}, 1, 1'b1, 32'h00000001, 1'b1, "samecyc_new_thr");

    // Reset mid-vector discards the partial vector and restores thresholds.
    for (int b = 0; b < 7; b++) send_beat(16'sd30000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_m_valid", 32'(m_valid), 32'd0);
    end
`ifdef QUANT_STATS_EN
    chk("stats_rst_vec", 32'(vec_count), 32'd0);
    chk("stats_rst_err", 32'(err_count), 32'd0);
`endif
    run_vec(alt, 16, 1'b1, 32'hE4E4E4E4, 1'b0, "postrst_full");
    run_vec({16{16'sd30000}}, 5, 1'b1, 32'h000003FF, 1'b1, "postrst_short");
    run_vec({16{16'sd0}}, 16, 1'b1, 32'hAAAAAAAA, 1'b0, "postrst_zero");
`ifdef QUANT_STATS_EN
    chk("stats_vec_count", 32'(vec_count), 32'd3);
    chk("stats_err_count", 32'(err_count), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
